// File: rtl/array_stream_deserializer.sv
// Rebuilds LANES-lane frames of LW-bit lanes from a one-word-per-cycle stream,
// double-buffered so one frame is presented while the next one fills.
module array_stream_deserializer #(
    parameter int W     = 32,
    parameter int LANES = 16,
    parameter int LW    = 17
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr,
    input  logic [W-1:0]          datain,
    input  logic                  valid,
    output logic                  in_ready,
    output logic [LANES*LW-1:0]   frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overflow,
    output logic                  trunc_err,
    output logic [15:0]           frame_count
);

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

    // True when the word carries information above the lane width.
    function automatic logic high_bits_set(input logic [W-1:0] word);
        logic [W-1:0] upper;
        upper = word >> LW;
        return |upper;
    endfunction

    logic [CW-1:0]          cnt_r;
    logic                   wb_r;
    logic                   rb_r;
    logic [1:0]             full_r;
    logic [LANES*LW-1:0]    bank_r [2];
    logic                   overflow_r;
    logic                   trunc_r;
    logic [15:0]            count_r;

    logic                   accept_s;
    logic                   drop_s;
    logic                   complete_s;
    logic                   release_s;
    logic [1:0]             full_nxt_s;

    // Handshake decode; clr masks every event so it wins over valid and frame_ready.
    always_comb begin
        accept_s   = 1'b0;
        drop_s     = 1'b0;
        complete_s = 1'b0;
        release_s  = 1'b0;
        if (clr) begin
            accept_s   = 1'b0;
            drop_s     = 1'b0;
            complete_s = 1'b0;
            release_s  = 1'b0;
        end else begin
            accept_s   = valid & ~full_r[wb_r];
            drop_s     = valid &  full_r[wb_r];
            complete_s = valid & ~full_r[wb_r] & (cnt_r == LAST_LANE);
            release_s  = full_r[rb_r] & frame_ready;
        end
    end

    // Completion and release always hit different banks, so both updates can merge.
    always_comb begin
        full_nxt_s = full_r;
        if (complete_s) begin
            full_nxt_s[wb_r] = 1'b1;
        end else begin
            full_nxt_s[wb_r] = full_r[wb_r];
        end
        if (release_s) begin
            full_nxt_s[rb_r] = 1'b0;
        end else begin
            full_nxt_s[rb_r] = full_nxt_s[rb_r];
        end
    end

    // Lane counter, bank pointers, occupancy, flags and delivered-frame counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r      <= '0;
            wb_r       <= 1'b0;
            rb_r       <= 1'b0;
            full_r     <= 2'b00;
            overflow_r <= 1'b0;
            trunc_r    <= 1'b0;
            count_r    <= 16'd0;
        end else if (clr) begin
            cnt_r      <= '0;
            wb_r       <= 1'b0;
            rb_r       <= 1'b0;
            full_r     <= 2'b00;
            overflow_r <= 1'b0;
            trunc_r    <= 1'b0;
            count_r    <= 16'd0;
        end else begin
            full_r <= full_nxt_s;
            if (accept_s) begin
                cnt_r <= complete_s ? '0 : cnt_r + CW'(1);
                if (high_bits_set(datain)) begin
                    trunc_r <= 1'b1;
                end
            end
            if (complete_s) begin
                wb_r <= ~wb_r;
            end
            if (release_s) begin
                rb_r    <= ~rb_r;
                count_r <= count_r + 16'd1;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Frame storage; soft clear leaves the data in place, only reset zeroes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int b = 0; b < 2; b++) begin
                bank_r[b] <= '0;
            end
        end else if (accept_s) begin
            bank_r[wb_r][int'(cnt_r)*LW +: LW] <= datain[LW-1:0];
        end
    end

    assign in_ready    = ~full_r[wb_r];
    assign frame_valid = full_r[rb_r];
    assign frame_data  = bank_r[rb_r];
    assign overflow    = overflow_r;
    assign trunc_err   = trunc_r;
    assign frame_count = count_r;

endmodule

// File: tb/tb_array_stream_deserializer.sv
// Self-checking bench for array_stream_deserializer: directed scenarios plus a
// randomized run against a queue-based frame model.
module tb_array_stream_deserializer;

    localparam int W     = 32;
    localparam int LANES = 16;
    localparam int LW    = 17;
    localparam int FW    = LANES * LW;

    logic           clk = 1'b0;
    logic           resetn = 1'b1;
    logic           clr = 1'b0;
    logic [W-1:0]   datain = '0;
    logic           valid = 1'b0;
    logic           in_ready;
    logic [FW-1:0]  frame_data;
    logic           frame_valid;
    logic           frame_ready = 1'b0;
    logic           overflow;
    logic           trunc_err;
    logic [15:0]    frame_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: accepted-but-incomplete words and complete pending frames.
    logic [LW-1:0]  part_q[$];
    logic [FW-1:0]  pend_q[$];
    logic           m_ovf;
    logic           m_trunc;
    logic [15:0]    m_cnt;

    logic [W-1:0]   words [0:63];

    array_stream_deserializer #(.W(W), .LANES(LANES), .LW(LW)) dut (
        .clk(clk), .resetn(resetn), .clr(clr), .datain(datain), .valid(valid),
        .in_ready(in_ready), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .overflow(overflow), .trunc_err(trunc_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] pack(input int base);
        logic [FW-1:0] f;
        for (int i = 0; i < LANES; i++) f[i*LW +: LW] = words[base+i][LW-1:0];
        return f;
    endfunction

    task automatic model_clear();
        part_q.delete();
        pend_q.delete();
        m_ovf = 1'b0;
        m_trunc = 1'b0;
        m_cnt = 16'd0;
    endtask

    // One clock: drive inputs, advance the model at the edge, settle 1 time unit.
    task automatic step(input logic v, input logic [W-1:0] d, input logic fr, input logic c);
        logic rdy;
        logic rel;
        logic [FW-1:0] f;
        logic [W-1:0] upper;
        valid = v; datain = d; frame_ready = fr; clr = c;
        @(posedge clk);
        if (c) begin
            model_clear();
        end else begin
            rdy = (pend_q.size() < 2);
            rel = fr && (pend_q.size() > 0);
            if (rel) begin
                void'(pend_q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (v && rdy) begin
                part_q.push_back(d[LW-1:0]);
                upper = d >> LW;
                if (upper != '0) m_trunc = 1'b1;
                if (part_q.size() == LANES) begin
                    for (int i = 0; i < LANES; i++) f[i*LW +: LW] = part_q[i];
                    pend_q.push_back(f);
                    part_q.delete();
                end
            end else if (v) begin
                m_ovf = 1'b1;
            end
        end
        #1;
        valid = 1'b0; clr = 1'b0; frame_ready = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        resetn = 1'b0;
        model_clear();
        #3;
        vectors++;
        if ({in_ready, frame_valid, overflow, trunc_err, frame_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd0})
            begin miscompares++; $display("FAIL reset_flags: got %b_%b_%b_%b_%h want 1_0_0_0_0000",
                in_ready, frame_valid, overflow, trunc_err, frame_count); end
        vectors++;
        if (frame_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0", frame_data); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_fill_one();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < LANES; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b0);
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_in_ready w%0d: got %b want 1", i, in_ready); end
            vectors++;
            if (frame_valid !== (i == LANES-1)) begin miscompares++;
                $display("FAIL fill_valid w%0d: got %b want %b", i, frame_valid, (i == LANES-1)); end
        end
        for (int i = 0; i < LANES; i++) begin
            vectors++;
            if (frame_data[i*LW +: LW] !== LW'(i)) begin miscompares++;
                $display("FAIL fill_lane%0d: got %h want %h", i, frame_data[i*LW +: LW], LW'(i)); end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if ({frame_valid, frame_count} !== {1'b0, 16'd1}) begin miscompares++;
            $display("FAIL fill_release: got %b/%0d want 0/1", frame_valid, frame_count); end
    endtask

    task automatic test_stalled();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 33; k++) words[k] = $urandom;
        for (int k = 0; k < 32; k++) step(1'b1, words[k], 1'b0, 1'b0);
        vectors++;
        if ({in_ready, frame_valid} !== 2'b01) begin miscompares++;
            $display("FAIL stall_full: got rdy=%b fv=%b want 0 1", in_ready, frame_valid); end
        step(1'b1, words[32], 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL stall_overflow: got %b want 1", overflow); end
        vectors++;
        if (frame_data !== pack(0)) begin miscompares++; $display("FAIL stall_frame1: got %h want %h", frame_data, pack(0)); end
        step(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (frame_valid !== 1'b1 || frame_data !== pack(16)) begin miscompares++;
            $display("FAIL stall_frame2: got fv=%b %h want 1 %h", frame_valid, frame_data, pack(16)); end
        step(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if ({frame_valid, in_ready, frame_count} !== {1'b0, 1'b1, 16'd2}) begin miscompares++;
            $display("FAIL stall_drain: got fv=%b rdy=%b cnt=%0d want 0 1 2", frame_valid, in_ready, frame_count); end
    endtask

    task automatic test_streaming();
        int k;
        k = 0;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 64; n++) words[n] = $urandom;
        for (int n = 0; n <= 64; n++) begin
            step(n < 64, (n < 64) ? words[n] : '0, 1'b1, 1'b0);
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready n%0d: got %b want 1", n, in_ready); end
            vectors++;
            if (frame_valid !== (n % LANES == LANES-1)) begin miscompares++;
                $display("FAIL stream_valid n%0d: got %b want %b", n, frame_valid, (n % LANES == LANES-1)); end
            if (n % LANES == LANES-1) begin
                vectors++;
                if (frame_data !== pack(16*k)) begin miscompares++;
                    $display("FAIL stream_frame%0d: got %h want %h", k, frame_data, pack(16*k)); end
                k++;
            end
        end
        vectors++;
        if ({frame_count, overflow, frame_valid} !== {16'd4, 1'b0, 1'b0}) begin miscompares++;
            $display("FAIL stream_end: got cnt=%0d ovf=%b fv=%b want 4 0 0", frame_count, overflow, frame_valid); end
    endtask

    task automatic test_truncation();
        step(1'b0, '0, 1'b0, 1'b1);
        vectors++;
        if (trunc_err !== 1'b0) begin miscompares++; $display("FAIL trunc_clear: got %b want 0", trunc_err); end
        step(1'b1, 32'h0003_0001, 1'b0, 1'b0);
        vectors++;
        if (trunc_err !== 1'b1) begin miscompares++; $display("FAIL trunc_flag: got %b want 1", trunc_err); end
        for (int i = 1; i < LANES; i++) step(1'b1, 32'h0000_0000, 1'b0, 1'b0);
        vectors++;
        if (frame_data[LW-1:0] !== 17'h1_0001 || frame_valid !== 1'b1) begin miscompares++;
            $display("FAIL trunc_lane: got fv=%b %h want 1 10001", frame_valid, frame_data[LW-1:0]); end
        step(1'b0, '0, 1'b0, 1'b1);
        vectors++;
        if ({trunc_err, overflow, frame_valid, frame_count} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin miscompares++;
            $display("FAIL trunc_clr: got %b %b %b %0d want 0 0 0 0", trunc_err, overflow, frame_valid, frame_count); end
    endtask

    task automatic test_abort();
        for (int mode = 0; mode < 2; mode++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 1'b0);
            if (mode == 0) step(1'b0, '0, 1'b0, 1'b1);
            else do_reset();
            for (int i = 0; i < LANES; i++) step(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
            vectors++;
            if ({frame_valid, frame_count} !== {1'b1, 16'd0}) begin miscompares++;
                $display("FAIL abort%0d_state: got fv=%b cnt=%0d want 1 0", mode, frame_valid, frame_count); end
            for (int i = 0; i < LANES; i++) begin
                vectors++;
                if (frame_data[i*LW +: LW] !== LW'(32'h100 + i)) begin miscompares++;
                    $display("FAIL abort%0d_lane%0d: got %h want %h", mode, i, frame_data[i*LW +: LW], LW'(32'h100 + i)); end
            end
        end
    endtask

    task automatic test_simultaneous();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 32; k++) words[k] = {15'd0, 17'($urandom)};
        for (int k = 0; k < 31; k++) step(1'b1, words[k], 1'b0, 1'b0);
        step(1'b1, words[31], 1'b1, 1'b0);
        vectors++;
        if ({frame_count, frame_valid, overflow, in_ready} !== {16'd1, 1'b1, 1'b0, 1'b1}) begin miscompares++;
            $display("FAIL simul_state: got cnt=%0d fv=%b ovf=%b rdy=%b want 1 1 0 1",
                frame_count, frame_valid, overflow, in_ready); end
        vectors++;
        if (frame_data !== pack(16)) begin miscompares++; $display("FAIL simul_frame2: got %h want %h", frame_data, pack(16)); end
    endtask

    task automatic test_random();
        logic v, fr, c;
        logic [W-1:0] d;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 600; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            fr = ($urandom_range(0, 2) == 0);
            c  = ($urandom_range(0, 80) == 0);
            d  = ($urandom_range(0, 20) == 0) ? $urandom : {15'd0, 17'($urandom)};
            step(v, d, fr, c);
            vectors++;
            if ({in_ready, frame_valid, overflow, trunc_err, frame_count} !==
                {(pend_q.size() < 2), (pend_q.size() > 0), m_ovf, m_trunc, m_cnt}) begin
                miscompares++;
                $display("FAIL rand_ctrl n%0d: got %b%b%b%b cnt=%0d want %b%b%b%b cnt=%0d", n,
                    in_ready, frame_valid, overflow, trunc_err, frame_count,
                    (pend_q.size() < 2), (pend_q.size() > 0), m_ovf, m_trunc, m_cnt);
            end
            if (pend_q.size() > 0) begin
                vectors++;
                if (frame_data !== pend_q[0]) begin miscompares++;
                    $display("FAIL rand_data n%0d: got %h want %h", n, frame_data, pend_q[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_one();
        test_stalled();
        test_streaming();
        test_truncation();
        test_abort();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/array_stream_deserializer.md
Name: array_stream_deserializer

Overview:
- Receive-side counterpart of the array serializer: accepts the serialized W-bit result stream (one word per valid cycle) and rebuilds 16-lane array frames of 17-bit lanes.
- Double-buffered (two frame banks): one frame is presented to the consumer while the next one fills.
- Sits between the array stream output and the downstream consumer (DMA or bus slave), with a valid/ready frame handshake and error flags.

Parameters:
- W, 32, stream word width (must be at least LW).
- LANES, 16, lanes per frame.
- LW, 17, lane width; equals the array feed width.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous soft clear of counters, banks state and flags.
- datain  in  W  serialized stream word.
- valid  in  1  datain is valid this cycle.
- in_ready  out  1  the write bank can accept a word.
- frame_data  out  LANES*LW  presented frame; lane i = bits [i*LW +: LW].
- frame_valid  out  1  a complete frame is presented.
- frame_ready  in  1  consumer accepts the frame.
- overflow  out  1  sticky: a word arrived while both banks were full.
- trunc_err  out  1  sticky: an accepted word had nonzero bits [W-1:LW].
- frame_count  out  16  frames delivered (handshakes), wraps at 0xFFFF to 0.

Behaviour:
- Reset (resetn=0, async) values:
  - lane counter cnt=0, write bank wb=0, read bank rb=0, full[1:0]=0.
  - in_ready=1, frame_valid=0, overflow=0, trunc_err=0, frame_count=0.
  - frame_data = bank contents, which are cleared to 0.
- Combinational outputs:
  - in_ready = ~full[wb].
  - frame_valid = full[rb].
  - frame_data = bank[rb].
- Accept rule: on valid & in_ready:
  - bank[wb][cnt] <= datain[LW-1:0].
  - trunc_err <= 1 if datain[W-1:LW] != 0.
  - cnt <= cnt+1.
- Lane order: the first accepted word of a frame is lane 0, the last is lane LANES-1.
- Frame completion: an accept with cnt==LANES-1 sets cnt<=0, full[wb]<=1 and wb<=~wb. frame_valid rises the cycle after the last word (latency 1).
- Release: on frame_valid & frame_ready, full[rb]<=0, rb<=~rb and frame_count increments. The next bank, if full, is presented in the following cycle.
- Simultaneous completion and release: these always target different banks (wb is empty, rb is full), so both take effect in the same cycle.
- Drop: on valid & ~in_ready the word is discarded. cnt and the banks are unchanged, and overflow <= 1.
- Back-to-back:
  - With a continuously ready consumer, a 1-word-per-cycle stream is sustained with no drops.
  - With a stalled consumer, 2*LANES words are buffered; word 2*LANES+1 is dropped.
- clr (synchronous): takes priority over valid and frame_ready in the same cycle.
  - Effect: cnt=0, wb=rb=0, full=0, flags=0, frame_count=0.
  - Bank data is not cleared.
- Reset during a partial frame: the partial frame is discarded and the next accepted word is lane 0.
- ready without valid, or valid=0 with any datain: no state change.
- The trunc_err and overflow flags hold until clr or reset.

Test Plan:
- Fill one frame: after reset, send 16 words 0x00000000..0x0000000F on consecutive cycles with frame_ready=0. Required: frame_valid=1 one cycle after the 16th word, lane i = i, and in_ready stays 1.
- Stalled consumer: send 32 words, then word 33 with frame_ready=0. Required: in_ready=0 after word 32, word 33 dropped, overflow=1. Releasing the frame gives words 1-16, then the next frame gives words 17-32 unchanged.
- Streaming: send 64 words back-to-back with frame_ready=1. Required: 4 frames delivered, frame_count=4, overflow=0, and each frame's lanes equal the expected 17-bit values.
- Truncation: send a word 0x0003_0001 (W=32). Required: lane stores 0x1_0001 masked to 17 bits, i.e. 0x10001, and trunc_err=1.
- Abort mid-frame: send 7 words, then pulse clr (or assert resetn=0), then send 16 words 0x100+i. Required: one frame with lane i = 0x100+i, and frame_count=0 before that frame is released.
- Simultaneous events: in the cycle the 16th word of frame 2 arrives, assert frame_ready on frame 1. Required: frame 1 is released, frame 2 is presented the next cycle, frame_count=1, and no drop occurs.
